// File: rtl/mode_controller.sv
// mode_controller: board mode sequencer driving the counter enable, the LRU req/ack
// handshake and the 32-bit display word. Revision: 1.0
`default_nettype none

module mode_controller #(
    parameter int KEY_W   = 8,
    parameter int VAL_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mode_next_i,
    input  logic              exec_i,
    input  logic [15:0]       sw_i,
    input  logic [31:0]       cnt_val_i,
    output logic              cnt_en_o,
    output logic              lru_req_o,
    output logic              lru_we_o,
    output logic [KEY_W-1:0]  lru_key_o,
    output logic [VAL_W-1:0]  lru_wdata_o,
    input  logic              lru_ack_i,
    input  logic              lru_hit_i,
    input  logic [VAL_W-1:0]  lru_rdata_i,
    output logic [2:0]        state_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [31:0]       data_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        MODE_CNT = 2'd0,
        MODE_WR  = 2'd1,
        MODE_RD  = 2'd2
    } mode_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fsm_t;

    fsm_t              state, state_nxt;
    mode_t             mode;
    logic              run;
    logic              req_we;
    logic [CW-1:0]     tcnt;
    logic              err;
    logic [KEY_W-1:0]  key;
    logic [VAL_W-1:0]  wdata;
    logic [KEY_W-1:0]  last_key;
    logic [VAL_W-1:0]  last_val;
    logic [KEY_W-1:0]  rd_key;
    logic              rd_hit;
    logic [VAL_W-1:0]  rd_val;
    logic              start_req;
    logic              ack_take;
    logic              expire;
    logic              idle_exec;

    // mode_next outranks exec; both are dropped outright while a request is open
    assign idle_exec = (state == ST_IDLE) && exec_i && !mode_next_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_req = 1'b0;
        ack_take  = 1'b0;
        expire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (idle_exec && (mode != MODE_CNT)) begin
                    start_req = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (lru_ack_i) begin
                    ack_take  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tcnt == C_LAST) begin
                    expire    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mode     <= MODE_CNT;
            run      <= 1'b1;
            req_we   <= 1'b0;
            tcnt     <= '0;
            err      <= 1'b0;
            key      <= '0;
            wdata    <= '0;
            last_key <= '0;
            last_val <= '0;
            rd_key   <= '0;
            rd_hit   <= 1'b0;
            rd_val   <= '0;
        end else begin
            if ((state == ST_IDLE) && mode_next_i) begin
                case (mode)
                    MODE_CNT: mode <= MODE_WR;
                    MODE_WR:  mode <= MODE_RD;
                    default:  mode <= MODE_CNT;
                endcase
            end
            if (idle_exec && (mode == MODE_CNT))
                run <= ~run;
            if (start_req) begin
                tcnt   <= '0;
                err    <= 1'b0;
                req_we <= (mode == MODE_WR);
                key    <= sw_i[15 -: KEY_W];
                if (mode == MODE_WR)
                    wdata <= sw_i[VAL_W-1:0];
            end else if (state == ST_REQ) begin
                tcnt <= tcnt + CW'(1);
            end
            if (expire)
                err <= 1'b1;
            if (ack_take) begin
                if (req_we) begin
                    last_key <= key;
                    last_val <= wdata;
                end else begin
                    rd_key <= key;
                    rd_hit <= lru_hit_i;
                    rd_val <= lru_rdata_i;
                end
            end
        end
    end

    assign busy_o      = (state == ST_REQ);
    assign lru_req_o   = busy_o;
    assign lru_we_o    = busy_o & req_we;
    assign lru_key_o   = key;
    assign lru_wdata_o = wdata;
    assign err_o       = err;
    assign cnt_en_o    = (mode == MODE_CNT) & run;

    always_comb begin
        state_o = 3'b100;
        data_o  = cnt_val_i;
        case (mode)
            MODE_WR: begin
                state_o = 3'b010;
                data_o  = {8'(last_key), 8'(last_val), 16'h0000};
            end
            MODE_RD: begin
                state_o = 3'b001;
                data_o  = {8'(rd_key), 7'b0, rd_hit, 8'h00, 8'(rd_val)};
            end
            default: begin
                state_o = 3'b100;
                data_o  = cnt_val_i;
            end
        endcase
    end

endmodule

`default_nettype wire
